// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory slave for the core's req/gnt/rvalid
// interface. Byte-enabled word array, fixed-latency in-order responses,
// bounded outstanding requests and an optional periodic grant-stall generator.
module data_mem_responder #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WORDS      = 1024,
    parameter int RVALID_LATENCY   = 1,
    parameter int MAX_OUTSTANDING  = 2,
    parameter int GNT_STALL_PERIOD = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [DATA_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int STALL_W = (GNT_STALL_PERIOD > 1) ? $clog2(GNT_STALL_PERIOD) : 1;
    localparam int LAT     = RVALID_LATENCY;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]   idx;
    logic [OUT_W-1:0]   outstanding;
    logic [STALL_W-1:0] stall_cnt;
    logic               stall;
    logic               accept;

    // Response pipeline: stage 0 is loaded at the accept edge, stage LAT-1 drives the outputs.
    logic [LAT-1:0]                 vld_p;
    logic [LAT-1:0]                 wr_p;
    logic [LAT-1:0][DATA_WIDTH-1:0] rdata_p;

    // Byte offset and address bits above the array are dropped, so addresses alias.
    logic unused_addr;
    assign unused_addr = ^{data_addr_i[DATA_WIDTH-1:IDX_W+2], data_addr_i[1:0]};
    assign idx         = data_addr_i[IDX_W+1:2];

    assign stall = (GNT_STALL_PERIOD != 0) && (stall_cnt == STALL_W'(GNT_STALL_PERIOD - 1));

    // The rvalid term lets a new request in on the same cycle a slot frees up.
    assign data_gnt_o = rst_ni && data_req_i && !stall &&
                        ((outstanding < OUT_W'(MAX_OUTSTANDING)) || data_rvalid_o);
    assign accept     = data_req_i && data_gnt_o;

    // Free-running stall counter, wraps at GNT_STALL_PERIOD-1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (GNT_STALL_PERIOD == 0) begin
            stall_cnt <= '0;
        end else if (stall_cnt == STALL_W'(GNT_STALL_PERIOD - 1)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Accepted-but-unanswered count; accept and rvalid in the same cycle cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else begin
            case ({accept, data_rvalid_o})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Response valids: reset drops anything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p <= '0;
        end else begin
            for (int k = LAT - 1; k > 0; k--) begin
                vld_p[k] <= vld_p[k-1];
            end
            vld_p[0] <= accept;
        end
    end

    // Memory array write and stage-0 read capture; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
        wr_p[0]    <= data_we_i;
        rdata_p[0] <= mem[idx];
        for (int k = LAT - 1; k > 0; k--) begin
            wr_p[k]    <= wr_p[k-1];
            rdata_p[k] <= rdata_p[k-1];
        end
    end

    // Output stage: data is zero unless a read response is presented.
    assign data_rvalid_o = vld_p[LAT-1];
    assign data_rdata_o  = (vld_p[LAT-1] && !wr_p[LAT-1]) ? rdata_p[LAT-1] : '0;

`ifndef SYNTHESIS
    // Outstanding count must never underflow nor exceed MAX_OUTSTANDING.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(data_rvalid_o && !accept && outstanding == '0));
            assert (!(accept && !data_rvalid_o && outstanding == OUT_W'(MAX_OUTSTANDING)));
        end
    end
`endif

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data memory slave on the CPU's request/grant/rvalid data interface: the responder that the memory stage's load/store unit talks to. It accepts one request per cycle and performs byte-enabled writes into an internal word array. Every accepted request gets exactly one in-order response after a fixed latency. Used as the data RAM in the core testbench and FPGA top, with a deterministic grant-stall generator to exercise initiator back-pressure.

## Interface
- DATA_WIDTH, 32, data/address width (fixed 32; other values unsupported)
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥4
- RVALID_LATENCY, 1, cycles from acceptance to rvalid; legal 1..4
- MAX_OUTSTANDING, 2, accepted-but-unanswered request limit; legal 1..RVALID_LATENCY+1
- GNT_STALL_PERIOD, 0, 0 = no forced stalls; N≥2 = gnt forced low one cycle in every N

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  request valid from initiator
- data_gnt_o  out  1  grant; request accepted when data_req_i && data_gnt_o
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables for writes; ignored for reads
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid, one cycle per accepted request
- data_rdata_o  out  32  read data; 0 for write responses and when rvalid low

## Operation
- Word index = data_addr_i[log2(DEPTH_WORDS)+1:2]; addr[1:0] and upper bits ignored, so out-of-range addresses alias.
- Grant is combinational: data_gnt_o = data_req_i && !stall && (outstanding < MAX_OUTSTANDING || data_rvalid_o).
- stall = (GNT_STALL_PERIOD != 0) && (stall_cnt == GNT_STALL_PERIOD-1).
- stall_cnt is free-running, counts 0..GNT_STALL_PERIOD-1, and wraps to 0.
- Write acceptance: at that clock edge, byte lane i of mem[index] is written with wdata[8i+7:8i] where be[i]=1. be=0000 is legal and leaves memory unchanged.
- Read acceptance: at that clock edge, mem[index] is captured into response stage 0.
- Response pipeline: RVALID_LATENCY-deep shift register of {valid, is_write, rdata}, advanced every cycle. The output stage drives data_rvalid_o and data_rdata_o (forced 0 if is_write).
- outstanding counter (width clog2(MAX_OUTSTANDING+1)) behaviour:
  - +1 on acceptance.
  - −1 on data_rvalid_o.
  - Unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING or underflows (assertion).
- No cancellation: once granted, a response always follows. Request fields are sampled only in the accept cycle.
- Memory contents are not reset. The array may be preloaded via $readmemh on a plusarg-selected file in simulation only.

## Timing
- Reset values: data_rvalid_o=0, data_rdata_o=0, outstanding=0, stall_cnt=0, all pipeline valids 0. data_gnt_o=0 during reset.
- Reset asserted mid-operation: in-flight responses are dropped; writes already accepted before the reset edge persist in the array.
- Latency: a request accepted in cycle N produces rvalid in cycle N+RVALID_LATENCY. Responses are strictly in acceptance order.
- Throughput: one request per cycle sustained when MAX_OUTSTANDING ≥ RVALID_LATENCY and no stall. With MAX_OUTSTANDING=1 and latency 1, back-to-back requests are granted every cycle via the rvalid term.
- Read-after-write to the same word in consecutive accept cycles returns the new data, since the write completes at the earlier edge.
- data_req_i deasserting while gnt is low is permitted (initiator's choice); the responder keeps no state for ungranted requests.

## Test plan
- Reset then idle: hold rst_ni=0 for 3 cycles, release with req=0 → rvalid=0, rdata=0, gnt=0 throughout.
- Write then read, defaults: write addr 0x10, wdata 0xDEADBEEF, be=1111 (cycle N); read 0x10 (cycle N+1) → rvalid at N+1 with rdata=0, rvalid at N+2 with rdata=0xDEADBEEF.
- Byte enables: with 0x11223344 stored at 0x20, write 0xAABBCCDD with be=0101, then read → 0x11BB33DD. A be=0000 write then read → unchanged.
- Aliasing: with DEPTH_WORDS=1024, write 0xCAFEF00D to 0x1004, read 0x0004 → 0xCAFEF00D. A read of 0x0006 returns the same word.
- Back-pressure: RVALID_LATENCY=3, MAX_OUTSTANDING=2, continuous reads → gnt pattern 1,1,0,1,1,0…; rvalid count equals accept count; data in order.
- Stall generator: GNT_STALL_PERIOD=4, req held high → gnt low in cycles 3, 7, 11 after reset release. Reset asserted with 2 responses in flight → no rvalid afterwards; outstanding returns to 0.
